// File: rtl/sound_timer_bank.sv
// Bank of programmable interval timers paced by one shared prescaler tick.
// Each channel emits a one-cycle terminal pulse and, in periodic mode, a square tone.
module sound_timer_bank #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned PRESC_DIV  = 1000,
  parameter int unsigned PERIOD_RST = 1,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                EN,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_period,
  input  logic                wr_mode,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] Z,
  output logic [CHANNELS-1:0] tone,
  output logic [CHANNELS-1:0] busy
);

  localparam int unsigned      PS_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESC_DIV - 1);
  localparam logic [WIDTH-1:0] P_RST   = WIDTH'(PERIOD_RST);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic                tick;
  logic                wr_valid;
  state_e              state_q  [CHANNELS];
  state_e              state_d  [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [WIDTH-1:0]    period_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] tone_q, tone_d;
  logic [CHANNELS-1:0] z_q, z_d;

  always_comb begin
    tick     = EN && (presc_q == PS_LAST);
    presc_d  = presc_q;
    if (EN) begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
    end
    wr_valid = wr_en && (int'(wr_ch) < int'(CHANNELS));
    busy     = '0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      mode_d[i]   = mode_q[i];
      tone_d[i]   = tone_q[i];
      z_d[i]      = 1'b0;

      // stop beats start, and any start swallows the tick of its own cycle
      if (stop[i]) begin
        state_d[i] = IDLE;
        count_d[i] = '0;
        tone_d[i]  = 1'b0;
      end else if (start[i]) begin
        state_d[i] = RUN;
        count_d[i] = '0;
      end else if (state_q[i] == RUN && tick) begin
        if (count_q[i] == period_q[i]) begin
          z_d[i]     = 1'b1;
          count_d[i] = '0;
          if (mode_q[i]) begin
            tone_d[i] = ~tone_q[i];
          end else begin
            state_d[i] = IDLE;
          end
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
      end

      if (wr_valid && (int'(wr_ch) == int'(i))) begin
        period_d[i] = wr_period;
        mode_d[i]   = wr_mode;
      end

      busy[i] = (state_q[i] == RUN);
    end
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      presc_q <= '0;
      mode_q  <= '0;
      tone_q  <= '0;
      z_q     <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        period_q[i] <= P_RST;
      end
    end else begin
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      tone_q   <= tone_d;
      z_q      <= z_d;
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

  assign Z    = z_q;
  assign tone = tone_q;

endmodule
